// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cacheline to 64-bit burst memory adaptor
// Splits line writes into ascending beats and assembles read beats into a line.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i,
  output logic [31:0]            read_count,
  output logic [31:0]            write_count
);

  localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BEAT_W-1:0]       r_beat;
  logic [LINE_WIDTH-1:0]   r_buffer;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_is_read;
  logic [31:0]             r_read_count;
  logic [31:0]             r_write_count;
  logic                    w_beat_last;
  logic [ADDR_WIDTH-1:0]   w_aligned_addr;

  assign w_beat_last    = (r_beat == LAST_BEAT);
  assign w_aligned_addr = {address_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};

  assign line_o      = r_buffer;
  assign address_o   = r_addr;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    burst_o      = '0;
    case (r_state)
      IDLE: begin
        // Write wins when the L2 raises both requests together
        if (write_i) begin
          w_next_state = WRITE;
        end else if (read_i) begin
          w_next_state = READ;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && w_beat_last) begin
          w_next_state = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = r_buffer[r_beat*BURST_WIDTH +: BURST_WIDTH];
        if (resp_i && w_beat_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        resp_o       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat        <= '0;
      r_buffer      <= '0;
      r_addr        <= '0;
      r_is_read     <= 1'b0;
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (write_i) begin
            r_buffer  <= line_i;
            r_addr    <= w_aligned_addr;
            r_beat    <= '0;
            r_is_read <= 1'b0;
          end else if (read_i) begin
            r_addr    <= w_aligned_addr;
            r_beat    <= '0;
            r_is_read <= 1'b1;
          end
        end
        READ: begin
          if (resp_i) begin
            r_buffer[r_beat*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        DONE: begin
          if (r_is_read) begin
            r_read_count <= r_read_count + 32'd1;
          end else begin
            r_write_count <= r_write_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed vector bench for cacheline_adaptor
// Per-cycle vector table plus hand sequences for gapped beats, reset and counter wrap.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic [31:0]  read_count;
  logic [31:0]  write_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk         (clk),
    .rst         (rst),
    .line_i      (line_i),
    .line_o      (line_o),
    .address_i   (address_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .resp_o      (resp_o),
    .burst_i     (burst_i),
    .burst_o     (burst_o),
    .address_o   (address_o),
    .read_o      (read_o),
    .write_o     (write_o),
    .resp_i      (resp_i),
    .read_count  (read_count),
    .write_count (write_count)
  );

  typedef struct {
    logic         rs, rd, wr, rp;
    logic [63:0]  bu;
    logic [31:0]  ad;
    logic [255:0] ln;
    logic         e_ro, e_wo, e_resp;
    logic [63:0]  e_bu;
    logic [31:0]  e_ad, e_rc, e_wc;
    logic         chk_line;
    logic [255:0] e_ln;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] B1 = {16{4'h1}};
  localparam logic [63:0] B2 = {16{4'h2}};
  localparam logic [63:0] B3 = {16{4'h3}};
  localparam logic [63:0] B4 = {16{4'h4}};
  localparam logic [63:0] WA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] WB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] WC = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] WD = 64'hDDDD_0000_0000_000D;
  localparam logic [63:0] S0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] S1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] S2 = 64'h5A5A_A5A5_0F0F_F0F0;
  localparam logic [63:0] S3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] JK = 64'h9999_8888_7777_6666;

  function automatic vec_t mk(input logic rs, rd, wr, rp, input logic [63:0] bu,
                              input logic [31:0] ad, input logic [255:0] ln,
                              input logic ero, ewo, ersp, input logic [63:0] ebu,
                              input logic [31:0] ead, erc, ewc,
                              input logic cl, input logic [255:0] eln);
    vec_t v;
    v.rs = rs; v.rd = rd; v.wr = wr; v.rp = rp; v.bu = bu; v.ad = ad; v.ln = ln;
    v.e_ro = ero; v.e_wo = ewo; v.e_resp = ersp; v.e_bu = ebu;
    v.e_ad = ead; v.e_rc = erc; v.e_wc = ewc; v.chk_line = cl; v.e_ln = eln;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_read(input string tag, input logic [31:0] ad,
                          input logic [63:0] b0, b1, b2, b3);
    logic [63:0] bs [4];
    bs = '{b0, b1, b2, b3};
    @(negedge clk);
    read_i = 1'b1; address_i = ad; resp_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " accept read_o"}, read_o, 1'b1);
    chk({tag, " address_o"}, address_o, {ad[31:5], 5'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = bs[i];
      @(posedge clk); #1;
      if (i < 3) begin
        chk($sformatf("%s beat%0d read_o", tag, i), read_o, 1'b1);
        chk($sformatf("%s beat%0d resp_o", tag, i), resp_o, 1'b0);
      end else begin
        chk({tag, " done resp_o"}, resp_o, 1'b1);
        chk({tag, " done read_o"}, read_o, 1'b0);
        chk({tag, " done line_o"}, line_o, {b3, b2, b1, b0});
      end
    end
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle resp_o"}, resp_o, 1'b0);
  endtask

  initial begin
    logic [63:0] g [4];
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;

    // reset, then a back-to-back read at 0xC94
    vecs.push_back(mk(1,0,0,0, 0, 0, 0,            0,0,0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,0, 0, 32'hC94, 0,      1,0,0, 0, 32'hC80, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,1, B1, 32'hC94, 0,     1,0,0, 0, 32'hC80, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,1, B2, 32'hC94, 0,     1,0,0, 0, 32'hC80, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,1, B3, 32'hC94, 0,     1,0,0, 0, 32'hC80, 0, 0, 0, 0));
    vecs.push_back(mk(0,1,0,1, B4, 32'hC94, 0,     0,0,1, 0, 32'hC80, 0, 0, 1, {B4,B3,B2,B1}));
    vecs.push_back(mk(0,0,0,1, JK, 32'hC94, 0,     0,0,0, 0, 32'hC80, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,0,1, JK, 32'hC94, 0,     0,0,0, 0, 32'hC80, 1, 0, 0, 0));
    // write, with line_i/address_i disturbed after accept
    vecs.push_back(mk(0,0,1,0, 0, 32'h1234_5678, {WD,WC,WB,WA}, 0,1,0, WA, 32'h1234_5660, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,1,1, 0, 32'hFFFF_FFFF, {4{JK}},       0,1,0, WB, 32'h1234_5660, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,1,1, 0, 32'hFFFF_FFFF, {4{JK}},       0,1,0, WC, 32'h1234_5660, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,1,1, 0, 32'hFFFF_FFFF, {4{JK}},       0,1,0, WD, 32'h1234_5660, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,1,1, 0, 32'hFFFF_FFFF, {4{JK}},       0,0,1, 0,  32'h1234_5660, 1, 0, 0, 0));
    vecs.push_back(mk(0,0,0,0, 0, 32'hFFFF_FFFF, {4{JK}},       0,0,0, 0,  32'h1234_5660, 1, 1, 0, 0));
    // simultaneous read and write requests: write wins
    vecs.push_back(mk(0,1,1,0, 0, 32'h0000_0040, {S3,S2,S1,S0}, 0,1,0, S0, 32'h0000_0040, 1, 1, 0, 0));
    vecs.push_back(mk(0,1,1,1, 0, 32'h0000_0040, {S3,S2,S1,S0}, 0,1,0, S1, 32'h0000_0040, 1, 1, 0, 0));
    vecs.push_back(mk(0,1,1,1, 0, 32'h0000_0040, {S3,S2,S1,S0}, 0,1,0, S2, 32'h0000_0040, 1, 1, 0, 0));
    vecs.push_back(mk(0,1,1,1, 0, 32'h0000_0040, {S3,S2,S1,S0}, 0,1,0, S3, 32'h0000_0040, 1, 1, 0, 0));
    vecs.push_back(mk(0,1,1,1, 0, 32'h0000_0040, {S3,S2,S1,S0}, 0,0,1, 0,  32'h0000_0040, 1, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0, 0, 32'h0000_0040, {S3,S2,S1,S0}, 0,0,0, 0,  32'h0000_0040, 1, 2, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rs; read_i = vecs[i].rd; write_i = vecs[i].wr; resp_i = vecs[i].rp;
      burst_i = vecs[i].bu; address_i = vecs[i].ad; line_i = vecs[i].ln;
      @(posedge clk); #1;
      chk($sformatf("v%0d read_o", i), read_o, vecs[i].e_ro);
      chk($sformatf("v%0d write_o", i), write_o, vecs[i].e_wo);
      chk($sformatf("v%0d resp_o", i), resp_o, vecs[i].e_resp);
      chk($sformatf("v%0d burst_o", i), burst_o, vecs[i].e_bu);
      chk($sformatf("v%0d address_o", i), address_o, vecs[i].e_ad);
      chk($sformatf("v%0d read_count", i), read_count, vecs[i].e_rc);
      chk($sformatf("v%0d write_count", i), write_count, vecs[i].e_wc);
      if (vecs[i].chk_line) chk($sformatf("v%0d line_o", i), line_o, vecs[i].e_ln);
    end

    // gapped read: two idle cycles before every beat
    g = '{64'h0706_0504_0302_0100, 64'h1716_1514_1312_1110,
          64'h2726_2524_2322_2120, 64'h3736_3534_3332_3130};
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_201F; resp_i = 1'b0;
    @(posedge clk); #1;
    chk("gap accept read_o", read_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        resp_i = 1'b0; burst_i = JK;
        @(posedge clk); #1;
        chk($sformatf("gap b%0d idle%0d read_o", i, k), read_o, 1'b1);
        chk($sformatf("gap b%0d idle%0d resp_o", i, k), resp_o, 1'b0);
      end
      @(negedge clk);
      resp_i = 1'b1; burst_i = g[i];
      @(posedge clk); #1;
      chk($sformatf("gap b%0d resp_o", i), resp_o, (i == 3) ? 1'b1 : 1'b0);
      chk($sformatf("gap b%0d read_o", i), read_o, (i == 3) ? 1'b0 : 1'b1);
    end
    chk("gap line_o", line_o, {g[3], g[2], g[1], g[0]});
    chk("gap address_o", address_o, 32'h0000_2000);
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    @(posedge clk); #1;
    chk("gap read_count", read_count, 32'd2);

    // reset after two read beats
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_0100;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = JK;
      @(posedge clk);
    end
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst read_o", read_o, 1'b0);
    chk("rst resp_o", resp_o, 1'b0);
    chk("rst read_count", read_count, 32'd0);
    chk("rst write_count", write_count, 32'd0);
    chk("rst line_o", line_o, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst idle read_o", read_o, 1'b0);
    run_read("recover", 32'h0000_0100, S0, S1, S2, S3);
    chk("recover read_count", read_count, 32'd1);

    // read counter wrap
    @(negedge clk);
    force dut.r_read_count = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.r_read_count;
    #1;
    chk("wrap preset read_count", read_count, 32'hFFFF_FFFF);
    run_read("wrap", 32'hFFFF_FFE7, B4, B3, B2, B1);
    chk("wrap read_count", read_count, 32'd0);
    chk("wrap write_count", write_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
